// File: rtl/scaled_display.sv
// VGA scan-out with power-of-two upscaling, centred letterbox, RGB444/RGB332 decode
// and vblank-aligned double-buffer swap. Pins lag the raster counters by READ_LATENCY+1.
module scaled_display #(
    parameter int          H_RES        = 640,
    parameter int          H_FP         = 16,
    parameter int          H_SYNC       = 96,
    parameter int          H_BP         = 48,
    parameter int          V_RES        = 480,
    parameter int          V_FP         = 10,
    parameter int          V_SYNC       = 2,
    parameter int          V_BP         = 33,
    parameter bit          H_POL        = 1'b0,
    parameter bit          V_POL        = 1'b0,
    parameter int          BUF_W        = 160,
    parameter int          BUF_H        = 120,
    parameter int          SCALE_SHIFT  = 2,
    parameter int          PIXEL_BITS   = 12,
    parameter int          READ_LATENCY = 1,
    parameter logic [11:0] BORDER_RGB   = 12'h000,
    parameter int          ADDR_W       = $clog2(BUF_W * BUF_H) + 1
) (
    input  logic                  clk_pixel,
    input  logic                  rst_pixel,
    input  logic                  swap_req,
    output logic [ADDR_W-1:0]     read_addr,
    input  logic [PIXEL_BITS-1:0] read_data,
    output logic                  vga_hsync,
    output logic                  vga_vsync,
    output logic [3:0]            vga_red,
    output logic [3:0]            vga_green,
    output logic [3:0]            vga_blue,
    output logic                  front_buf,
    output logic                  swap_done,
    output logic                  frame_start,
    output logic                  vblank
);

    localparam int LW    = H_RES + H_FP + H_SYNC + H_BP;
    localparam int LH    = V_RES + V_FP + V_SYNC + V_BP;
    localparam int XW    = $clog2(LW);
    localparam int YW    = $clog2(LH);
    localparam int IMG_W = BUF_W << SCALE_SHIFT;
    localparam int IMG_H = BUF_H << SCALE_SHIFT;
    localparam int X_OFF = (H_RES - IMG_W) / 2;
    localparam int Y_OFF = (V_RES - IMG_H) / 2;
    localparam int PA_W  = ADDR_W - 1;

    if (PIXEL_BITS != 12 && PIXEL_BITS != 8) begin : g_bad_format
        $error("scaled_display: PIXEL_BITS must be 8 or 12");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("scaled_display: READ_LATENCY must be 1..4");
    end
    if (IMG_W > H_RES || IMG_H > V_RES) begin : g_bad_window
        $error("scaled_display: scaled image larger than active area");
    end

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          x_last, y_last;

    assign x_last = (x == XW'(LW - 1));
    assign y_last = (y == YW'(LH - 1));

    always_ff @(posedge clk_pixel or posedge rst_pixel) begin
        if (rst_pixel) begin
            x <= '0;
            y <= '0;
        end else if (x_last) begin
            x <= '0;
            y <= y_last ? '0 : y + 1'b1;
        end else begin
            x <= x + 1'b1;
        end
    end

    logic            in_win, de, hs, vs;
    logic [31:0]     rel_x, rel_y;
    logic [PA_W-1:0] pix_addr;

    always_comb begin
        de       = (32'(x) < H_RES) && (32'(y) < V_RES);
        in_win   = (32'(x) >= X_OFF) && (32'(x) < X_OFF + IMG_W) &&
                   (32'(y) >= Y_OFF) && (32'(y) < Y_OFF + IMG_H);
        hs       = (32'(x) >= H_RES + H_FP) && (32'(x) < H_RES + H_FP + H_SYNC);
        vs       = (32'(y) >= V_RES + V_FP) && (32'(y) < V_RES + V_FP + V_SYNC);
        rel_x    = 32'(x) - X_OFF;
        rel_y    = 32'(y) - Y_OFF;
        pix_addr = PA_W'(((rel_y >> SCALE_SHIFT) * BUF_W) + (rel_x >> SCALE_SHIFT));
        read_addr = {front_buf, in_win ? pix_addr : {PA_W{1'b0}}};
    end

    assign vblank = (32'(y) >= V_RES);

    // Stage flags are {window, data-enable, hsync, vsync}, all active-high internally.
    logic [3:0] dly [READ_LATENCY];
    logic [3:0] tail;

    always_ff @(posedge clk_pixel or posedge rst_pixel) begin
        if (rst_pixel) begin
            for (int i = 0; i < READ_LATENCY; i++) dly[i] <= 4'b0000;
        end else begin
            dly[0] <= {in_win, de, hs, vs};
            for (int i = 1; i < READ_LATENCY; i++) dly[i] <= dly[i-1];
        end
    end

    assign tail = dly[READ_LATENCY-1];

    logic [11:0] pix_rgb;
    if (PIXEL_BITS == 12) begin : g_rgb444
        assign pix_rgb = read_data;
    end else begin : g_rgb332
        assign pix_rgb = {read_data[7:6], read_data[7:6],
                          read_data[5:3], read_data[5],
                          read_data[2:0], read_data[2]};
    end

    logic [11:0] out_rgb;
    always_comb begin
        out_rgb = 12'h000;
        if (tail[2]) out_rgb = tail[3] ? pix_rgb : BORDER_RGB;
    end

    always_ff @(posedge clk_pixel or posedge rst_pixel) begin
        if (rst_pixel) begin
            vga_hsync <= ~H_POL;
            vga_vsync <= ~V_POL;
            vga_red   <= 4'h0;
            vga_green <= 4'h0;
            vga_blue  <= 4'h0;
        end else begin
            vga_hsync <= tail[1] ? H_POL : ~H_POL;
            vga_vsync <= tail[0] ? V_POL : ~V_POL;
            vga_red   <= out_rgb[3:0];
            vga_green <= out_rgb[7:4];
            vga_blue  <= out_rgb[11:8];
        end
    end

    // A request landing on the swap point itself is taken immediately.
    logic pending, swap_point;
    assign swap_point = (x == '0) && (32'(y) == V_RES);

    always_ff @(posedge clk_pixel or posedge rst_pixel) begin
        if (rst_pixel) begin
            pending     <= 1'b0;
            front_buf   <= 1'b0;
            swap_done   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= x_last && y_last;
            swap_done   <= 1'b0;
            if (swap_point && (pending || swap_req)) begin
                front_buf <= ~front_buf;
                swap_done <= 1'b1;
                pending   <= 1'b0;
            end else if (swap_req) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scaled_display.sv
// Directed bench for scaled_display: three tiny-raster instances (RGB444 direct,
// letterboxed with green border, RGB332 at latency 3) sharing one clock and reset.
module tb_scaled_display;

    logic clk = 1'b0;
    logic rst;
    logic swap_a;
    int   cyc;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    // Instance A: 16x12 active, 4x3 buffer, RGB444, latency 1
    logic [4:0]  addr_a, ram_a_q;
    logic [11:0] data_a;
    logic        hs_a, vs_a, fb_a, sd_a, fs_a, vb_a;
    logic [3:0]  r_a, g_a, b_a;
    always @(posedge clk) ram_a_q <= addr_a;
    assign data_a = {7'b0, ram_a_q};

    scaled_display #(.H_RES(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_RES(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .BUF_W(4), .BUF_H(3), .SCALE_SHIFT(2), .PIXEL_BITS(12),
                     .READ_LATENCY(1), .BORDER_RGB(12'h000)) dut_a (
        .clk_pixel(clk), .rst_pixel(rst), .swap_req(swap_a),
        .read_addr(addr_a), .read_data(data_a),
        .vga_hsync(hs_a), .vga_vsync(vs_a),
        .vga_red(r_a), .vga_green(g_a), .vga_blue(b_a),
        .front_buf(fb_a), .swap_done(sd_a), .frame_start(fs_a), .vblank(vb_a));

    // Instance B: 3x2 buffer letterboxed at offset (2,2), green border
    logic [3:0]  addr_b, ram_b_q;
    logic [11:0] data_b;
    logic        hs_b, vs_b, fb_b, sd_b, fs_b, vb_b;
    logic [3:0]  r_b, g_b, b_b;
    always @(posedge clk) ram_b_q <= addr_b;
    assign data_b = {8'b0, ram_b_q};

    scaled_display #(.H_RES(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_RES(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .BUF_W(3), .BUF_H(2), .SCALE_SHIFT(2), .PIXEL_BITS(12),
                     .READ_LATENCY(1), .BORDER_RGB(12'h0F0)) dut_b (
        .clk_pixel(clk), .rst_pixel(rst), .swap_req(1'b0),
        .read_addr(addr_b), .read_data(data_b),
        .vga_hsync(hs_b), .vga_vsync(vs_b),
        .vga_red(r_b), .vga_green(g_b), .vga_blue(b_b),
        .front_buf(fb_b), .swap_done(sd_b), .frame_start(fs_b), .vblank(vb_b));

    // Instance C: RGB332 at latency 3; RAM returns 8'hAB only at address 9
    logic [4:0]  addr_c, a1_c, a2_c, a3_c;
    logic [7:0]  data_c;
    logic        hs_c, vs_c, fb_c, sd_c, fs_c, vb_c;
    logic [3:0]  r_c, g_c, b_c;
    always @(posedge clk) begin
        a1_c <= addr_c;
        a2_c <= a1_c;
        a3_c <= a2_c;
    end
    assign data_c = (a3_c == 5'd9) ? 8'b10_101_011 : 8'h00;

    scaled_display #(.H_RES(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_RES(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .BUF_W(4), .BUF_H(3), .SCALE_SHIFT(2), .PIXEL_BITS(8),
                     .READ_LATENCY(3), .BORDER_RGB(12'h000)) dut_c (
        .clk_pixel(clk), .rst_pixel(rst), .swap_req(1'b0),
        .read_addr(addr_c), .read_data(data_c),
        .vga_hsync(hs_c), .vga_vsync(vs_c),
        .vga_red(r_c), .vga_green(g_c), .vga_blue(b_c),
        .front_buf(fb_c), .swap_done(sd_c), .frame_start(fs_c), .vblank(vb_c));

    // Event tallies on instance A, cleared while reset is held
    int hs_low, vs_low, fs_count, fs_first, fs_last, sd_count;
    always @(negedge clk) begin
        if (rst) begin
            hs_low = 0; vs_low = 0; fs_count = 0;
            fs_first = 0; fs_last = 0; sd_count = 0;
        end else begin
            if (cyc >= 2 && cyc <= 385) begin
                if (!hs_a) hs_low++;
                if (!vs_a) vs_low++;
            end
            if (fs_a) begin
                fs_count++;
                if (fs_first == 0) fs_first = cyc;
                fs_last = cyc;
            end
            if (sd_a) sd_count++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic pulse_swap();
        swap_a = 1'b1;
        @(negedge clk);
        swap_a = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        swap_a = 1'b0;
        rst    = 1'b1;
        #3;
        chk("rst_hsync", hs_a, 1);
        chk("rst_vsync", vs_a, 1);
        chk("rst_red",   r_a, 0);
        chk("rst_green_b", g_b, 0);
        chk("rst_front", fb_a, 0);
        chk("rst_swap_done", sd_a, 0);
        chk("rst_frame_start", fs_a, 0);
        chk("rst_addr", addr_a, 0);
        chk("rst_vblank", vb_a, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Frame 0
        wait_cyc(2);   chk("b_border_00", g_b, 4'hF);
        wait_cyc(19);  chk("a_hsync_pre", hs_a, 1);
        wait_cyc(20);  chk("a_hsync_start", hs_a, 0);
        wait_cyc(21);  chk("c_hsync_pre", hs_c, 1);
        wait_cyc(22);  chk("c_hsync_start", hs_c, 0);
        wait_cyc(51);  chk("b_border_12", g_b, 4'hF);
        wait_cyc(52);  chk("b_win_22_green", g_b, 0);
        wait_cyc(64);  chk("b_border_right", g_b, 4'hF);
        wait_cyc(66);  chk("b_blank_green", g_b, 0);
        wait_cyc(78);  chk("b_addr_63", addr_b, 1);
        wait_cyc(80);  chk("b_red_63", r_b, 1);
        wait_cyc(100); pulse_swap();
        wait_cyc(221); chk("a_addr_59", addr_a, 9);
                       chk("a_red_39", r_a, 8);
        wait_cyc(222); chk("a_red_49", r_a, 9);
        wait_cyc(223); chk("c_red_39", r_c, 0);
        wait_cyc(224); chk("c_red_49", r_c, 4'h6);
                       chk("c_green_49", g_c, 4'hB);
                       chk("c_blue_49", b_c, 4'hA);
        wait_cyc(281); chk("a_red_last", r_a, 4'hB);
        wait_cyc(287); chk("a_vblank_pre", vb_a, 0);
        wait_cyc(288); chk("a_vblank", vb_a, 1);
                       chk("a_front_pre_swap", fb_a, 0);
        wait_cyc(289); chk("a_front_swap1", fb_a, 1);
                       chk("a_swap_done1", sd_a, 1);
        wait_cyc(290); chk("a_swap_done_end", sd_a, 0);
        wait_cyc(387); chk("a_hsync_low", hs_low, 48);
                       chk("a_vsync_low", vs_low, 48);
                       chk("a_fs_first", fs_first, 384);
                       chk("a_swaps_f0", sd_count, 1);

        // Frame 1: two requests merge into one swap
        wait_cyc(400); pulse_swap();
        wait_cyc(500); pulse_swap();
        wait_cyc(672); chk("a_front_pre_swap2", fb_a, 1);
        wait_cyc(673); chk("a_front_swap2", fb_a, 0);
                       chk("a_swap_done2", sd_a, 1);
        wait_cyc(770); chk("a_fs_period", fs_last, 768);
                       chk("a_fs_count", fs_count, 2);
                       chk("a_swaps_f1", sd_count, 2);

        // Frame 2: request exactly at the swap point
        wait_cyc(1056); chk("a_front_at_point", fb_a, 0);
        pulse_swap();
        chk("a_front_swap3", fb_a, 1);
        chk("a_swap_done3", sd_a, 1);
        wait_cyc(1441); chk("a_front_no_extra", fb_a, 1);
                        chk("a_swaps_f3", sd_count, 3);

        // Frame 3/4: leave a request pending, then reset mid-line
        wait_cyc(1450); pulse_swap();
        wait_cyc(1594); chk("a_red_front1", r_a, 2);
                        chk("a_green_front1", g_a, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_red", r_a, 0);
        chk("mid_rst_green", g_a, 0);
        chk("mid_rst_hsync", hs_a, 1);
        chk("mid_rst_vsync", vs_a, 1);
        chk("mid_rst_front", fb_a, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        wait_cyc(289); chk("post_rst_front", fb_a, 0);
        wait_cyc(387); chk("post_rst_no_swap", sd_count, 0);
                       chk("post_rst_fs_first", fs_first, 384);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
